// File: rtl/des_key_sched_seq.sv
// des_key_sched_seq: streaming DES key schedule, 16/KEYS_PER_CYCLE beats per key.
// Optional: define DES_KEY_PARITY_CHK_EN to reject even-parity key bytes (parity_err).
module des_key_sched_seq #(
   parameter int KEYS_PER_CYCLE = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         key_valid,
   output logic                         key_ready,
   input  logic [63:0]                  key_in,
   input  logic                         decrypt,
   output logic                         rk_valid,
   input  logic                         rk_ready,
   output logic [48*KEYS_PER_CYCLE-1:0] rk_data,
   output logic [3:0]                   rk_index,
   output logic                         rk_last,
   output logic                         busy
`ifdef DES_KEY_PARITY_CHK_EN
   ,
   output logic                         parity_err
`endif
);

   if (!(KEYS_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_kpc
      $error("KEYS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam int KPC = KEYS_PER_CYCLE;
   localparam logic [3:0] STEP     = 4'(KPC);
   localparam logic [3:0] LAST_ENC = 4'(16 - KPC);
   localparam logic [3:0] LAST_DEC = 4'(KPC - 1);

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   typedef enum logic [1:0] {IDLE, EMIT, PERR} state_t;

   state_t        state_q, state_d;
   logic [55:0]   cd_q, cd_src, cd_w;
   logic          dec_q, dec_src;
   logic [3:0]    idx_src, idx;
   logic [48*KPC-1:0] keys;
   logic          last_d;
   logic          accept, beat_hs, load, par_ok;

   // key_in[0] is DES bit 1; CD[55] is PC-1 position 1
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int j = 0; j < 56; j++) r[55-j] = k[PC1[j]-1];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int j = 0; j < 48; j++) r[47-j] = cd[56-PC2[j]];
      return r;
   endfunction

   function automatic logic [55:0] rot(input logic [55:0] x,
                                       input logic [3:0]  i,
                                       input logic        right);
      logic [27:0] c, d;
      logic        two;
      c = x[55:28];
      d = x[27:0];
      two = !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
      for (int n = 0; n < 2; n++) begin
         if (n == 0 || two) begin
            if (right) begin
               c = {c[0], c[27:1]};
               d = {d[0], d[27:1]};
            end else begin
               c = {c[26:0], c[27]};
               d = {d[26:0], d[27]};
            end
         end
      end
      return {c, d};
   endfunction

`ifdef DES_KEY_PARITY_CHK_EN
   always_comb begin
      par_ok = 1'b1;
      for (int b = 0; b < 8; b++)
         if (!(^key_in[8*b+7 -: 8])) par_ok = 1'b0;
   end
`else
   logic unused_par;
   assign unused_par = ^key_in;
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      beat_hs = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            accept = key_valid && key_ready;
            load   = accept && par_ok;
            if (accept) state_d = par_ok ? EMIT : PERR;
         end
         EMIT: begin
            beat_hs = rk_valid && rk_ready;
            if (beat_hs && rk_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Chain source is the fresh key at accept, else the look-ahead CD register
   always_comb begin
      dec_src = dec_q;
      cd_src  = cd_q;
      idx_src = dec_q ? rk_index - STEP : rk_index + STEP;
      if (state_q == IDLE) begin
         dec_src = decrypt;
         cd_src  = pc1(key_in);
         idx_src = decrypt ? 4'd15 : 4'd0;
      end
      keys = '0;
      cd_w = cd_src;
      idx  = idx_src;
      for (int j = 0; j < KPC; j++) begin
         if (!dec_src) begin
            cd_w = rot(cd_w, idx, 1'b0);
            keys[48*(KPC-j)-1 -: 48] = pc2(cd_w);
            idx = idx + 4'd1;
         end else begin
            keys[48*(KPC-j)-1 -: 48] = pc2(cd_w);
            cd_w = rot(cd_w, idx, 1'b1);
            idx = idx - 4'd1;
         end
      end
      last_d = dec_src ? (idx_src == LAST_DEC) : (idx_src == LAST_ENC);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cd_q      <= '0;
         dec_q     <= 1'b0;
         key_ready <= 1'b0;
         rk_valid  <= 1'b0;
         rk_data   <= '0;
         rk_index  <= '0;
         rk_last   <= 1'b0;
      end else begin
         key_ready <= (state_d == IDLE);
         if (load || (beat_hs && !rk_last)) begin
            cd_q     <= cd_w;
            rk_data  <= keys;
            rk_index <= idx_src;
            rk_last  <= last_d;
            rk_valid <= 1'b1;
            if (load) dec_q <= decrypt;
         end else if (beat_hs) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
         end
      end
   end

`ifdef DES_KEY_PARITY_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= (state_d == PERR);
   end
`endif

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_des_key_sched_seq.sv
// tb_des_key_sched_seq: directed checks of the DES key scheduler with
// KEYS_PER_CYCLE=1 and 4 against the classic 0x133457799BBCDFF1 schedule.
module tb_des_key_sched_seq;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          key_valid, kv4;
   logic          rk_ready, rr4;
   logic [63:0]   key_in;
   logic          decrypt;
   logic          key_ready1, rk_valid1, rk_last1, busy1;
   logic [47:0]   rk_data1;
   logic [3:0]    rk_index1;
   logic          key_ready4, rk_valid4, rk_last4, busy4;
   logic [191:0]  rk_data4;
   logic [3:0]    rk_index4;
`ifdef DES_KEY_PARITY_CHK_EN
   logic          perr1, perr4;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   des_key_sched_seq #(.KEYS_PER_CYCLE(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .key_valid(key_valid), .key_ready(key_ready1),
      .key_in(key_in), .decrypt(decrypt),
      .rk_valid(rk_valid1), .rk_ready(rk_ready),
      .rk_data(rk_data1), .rk_index(rk_index1),
      .rk_last(rk_last1), .busy(busy1)
`ifdef DES_KEY_PARITY_CHK_EN
      , .parity_err(perr1)
`endif
   );

   des_key_sched_seq #(.KEYS_PER_CYCLE(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .key_valid(kv4), .key_ready(key_ready4),
      .key_in(key_in), .decrypt(decrypt),
      .rk_valid(rk_valid4), .rk_ready(rr4),
      .rk_data(rk_data4), .rk_index(rk_index4),
      .rk_last(rk_last4), .busy(busy4)
`ifdef DES_KEY_PARITY_CHK_EN
      , .parity_err(perr4)
`endif
   );

   // K1..K16 for DES key 0x133457799BBCDFF1
   logic [47:0] kt [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

   typedef struct {
      logic        dec;
      int          beat;
      logic [47:0] data;
      logic [3:0]  idx;
      logic        last;
   } vec_t;

   vec_t vecs [32];
   logic [63:0] KEY;

   function automatic logic [63:0] rev64(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = x[63-i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [191:0] act,
                      input logic [191:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready1;
      int k;
      k = 0;
      while (key_ready1 !== 1'b1 && k < 50) begin
         tick;
         k++;
      end
      chk("key_ready1 wait", key_ready1, 1);
   endtask

   task automatic wait_ready4;
      int k;
      k = 0;
      while (key_ready4 !== 1'b1 && k < 50) begin
         tick;
         k++;
      end
      chk("key_ready4 wait", key_ready4, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] sd;
      logic [3:0]  si;
      logic        sl, stalled;
      int          n;
      logic [191:0] e4;

      KEY = rev64(64'h133457799BBCDFF1);
      for (int b = 0; b < 16; b++) begin
         vecs[b]    = '{1'b0, b, kt[b], 4'(b), b == 15};
         vecs[16+b] = '{1'b1, b, kt[15-b], 4'(15-b), b == 15};
      end

      rst_n = 1'b0; key_valid = 1'b0; kv4 = 1'b0;
      rk_ready = 1'b0; rr4 = 1'b0; key_in = '0; decrypt = 1'b0;
      #12;
      chk("rst rk_valid", rk_valid1, 0);
      chk("rst rk_data", rk_data1, 0);
      chk("rst rk_index", rk_index1, 0);
      chk("rst rk_last", rk_last1, 0);
      chk("rst busy", busy1, 0);
      chk("rst key_ready", key_ready1, 0);
      chk("rst rk_data4", rk_data4, 0);
`ifdef DES_KEY_PARITY_CHK_EN
      chk("rst parity_err", perr1, 0);
`endif
      tick;
      rst_n = 1'b1;
      chk("key_ready before edge", key_ready1, 0);
      tick;
      chk("key_ready after edge", key_ready1, 1);

      // table: KPC=1 encrypt then decrypt, rk_ready held high
      for (int v = 0; v < 32; v++) begin
         if (vecs[v].beat == 0) begin
            wait_ready1;
            key_valid = 1'b1; key_in = KEY;
            decrypt = vecs[v].dec; rk_ready = 1'b1;
            tick;
            key_valid = 1'b0; key_in = '1; decrypt = ~decrypt;
            chk("key_ready drop", key_ready1, 0);
`ifdef DES_KEY_PARITY_CHK_EN
            chk("good key parity_err", perr1, 0);
`endif
         end
         chk($sformatf("v%0d rk_valid", v), rk_valid1, 1);
         chk($sformatf("v%0d rk_data", v), rk_data1, vecs[v].data);
         chk($sformatf("v%0d rk_index", v), rk_index1, vecs[v].idx);
         chk($sformatf("v%0d rk_last", v), rk_last1, vecs[v].last);
         chk($sformatf("v%0d busy", v), busy1, 1);
         tick;
         if (vecs[v].last) begin
            chk($sformatf("v%0d end rk_valid", v), rk_valid1, 0);
            chk($sformatf("v%0d end key_ready", v), key_ready1, 1);
         end
      end

      // KPC=4, encrypt then decrypt
      for (int d = 0; d < 2; d++) begin
         wait_ready4;
         kv4 = 1'b1; key_in = KEY; decrypt = d[0]; rr4 = 1'b1;
         tick;
         kv4 = 1'b0;
         for (int b = 0; b < 4; b++) begin
            if (d == 0)
               e4 = {kt[4*b], kt[4*b+1], kt[4*b+2], kt[4*b+3]};
            else
               e4 = {kt[15-4*b], kt[14-4*b], kt[13-4*b], kt[12-4*b]};
            chk($sformatf("k4 d%0d b%0d valid", d, b), rk_valid4, 1);
            chk($sformatf("k4 d%0d b%0d data", d, b), rk_data4, e4);
            chk($sformatf("k4 d%0d b%0d index", d, b), rk_index4,
                (d == 0) ? 4*b : 15 - 4*b);
            chk($sformatf("k4 d%0d b%0d last", d, b), rk_last4, b == 3);
            tick;
         end
         chk($sformatf("k4 d%0d end valid", d), rk_valid4, 0);
         chk($sformatf("k4 d%0d end ready", d), key_ready4, 1);
      end
      rr4 = 1'b0;

      // backpressure with a stray key during EMIT
      wait_ready1;
      key_valid = 1'b1; key_in = KEY; decrypt = 1'b0; rk_ready = 1'b0;
      tick;
      key_valid = 1'b0;
      n = 0; stalled = 1'b0; sd = '0; si = '0; sl = 1'b0;
      for (int c = 0; c < 100 && n < 16; c++) begin
         if (stalled) begin
            chk("bp held data", rk_data1, sd);
            chk("bp held index", rk_index1, si);
            chk("bp held last", rk_last1, sl);
         end
         chk("bp key_ready low", key_ready1, 0);
         rk_ready  = c[0];
         key_valid = (c == 4);
         decrypt   = (c == 4);
         key_in    = (c == 4) ? 64'h0101010101010101 : KEY;
         if (rk_valid1 && rk_ready) begin
            chk($sformatf("bp beat %0d data", n), rk_data1, kt[n]);
            chk($sformatf("bp beat %0d index", n), rk_index1, n);
            chk($sformatf("bp beat %0d last", n), rk_last1, n == 15);
            n++;
            stalled = 1'b0;
         end else begin
            stalled = rk_valid1;
            sd = rk_data1; si = rk_index1; sl = rk_last1;
         end
         tick;
      end
      key_valid = 1'b0; rk_ready = 1'b1;
      chk("bp beat count", n, 16);
      chk("bp end key_ready", key_ready1, 1);
      chk("bp end rk_valid", rk_valid1, 0);
      for (int c = 0; c < 3; c++) begin
         tick;
         chk("bp stray not captured", rk_valid1, 0);
      end

      // reset mid-stream
      wait_ready1;
      key_valid = 1'b1; key_in = KEY; decrypt = 1'b0; rk_ready = 1'b1;
      tick;
      key_valid = 1'b0;
      repeat (5) tick;
      chk("mid beat5 index", rk_index1, 5);
      rst_n = 1'b0;
      #1;
      chk("mid rst rk_valid", rk_valid1, 0);
      chk("mid rst busy", busy1, 0);
      chk("mid rst index", rk_index1, 0);
      tick;
      chk("mid rst hold valid", rk_valid1, 0);
      tick;
      rst_n = 1'b1;
      wait_ready1;
      key_valid = 1'b1; key_in = 64'h0101010101010101; decrypt = 1'b0;
      tick;
      key_valid = 1'b0;
      chk("post rst valid", rk_valid1, 1);
      chk("post rst index", rk_index1, 0);
      chk("post rst busy", busy1, 1);
      wait_ready1;

`ifdef DES_KEY_PARITY_CHK_EN
      key_valid = 1'b1; key_in = 64'h0001010101010101; decrypt = 1'b0;
      tick;
      key_valid = 1'b0;
      chk("par pulse", perr1, 1);
      chk("par no rk_valid", rk_valid1, 0);
      chk("par key_ready low", key_ready1, 0);
      tick;
      chk("par pulse end", perr1, 0);
      chk("par key_ready back", key_ready1, 1);
      chk("par still no rk_valid", rk_valid1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential, streaming DES key scheduler; replaces the fully unrolled combinational 16-stage schedule in front of the round datapath.
- Accepts one 64-bit key per ready/valid handshake and emits the 16 round keys over 16/KEYS_PER_CYCLE output beats.
- Emission order is K1..K16 for encrypt or K16..K1 for decrypt, so the round core consumes keys in execution order with no key RAM.

Parameters:
- KEYS_PER_CYCLE, 1, round keys per output beat; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  key_in and decrypt valid.
- key_ready  out  1  block can accept a key.
- key_in  in  64  DES key with parity bits; key_in[0] is DES bit 1, key_in[63] is DES bit 64.
- decrypt  in  1  sampled with the key; 0 gives K1 first, 1 gives K16 first.
- rk_valid  out  1  rk_data valid.
- rk_ready  in  1  downstream accepts the beat.
- rk_data  out  48*KEYS_PER_CYCLE  round keys; the first-emitted key is in the top 48 bits. Within each key, bit 47 is PC-2 output position 1.
- rk_index  out  4  round number minus 1 of the first key in the beat.
- rk_last  out  1  final beat of the current key.
- busy  out  1  a key is held (state != IDLE).

Behaviour:
- Reset (rst_n low, async): state=IDLE, CD register=0, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, busy=0, key_ready=0.
- key_ready rises on the first clk edge after rst_n deasserts.
- States:
  - IDLE: key_ready=1. On key_valid&&key_ready: load CD <= PC-1(key_in) (CD[55] = PC-1 position 1; C = CD[55:28], D = CD[27:0]), latch decrypt, go to EMIT. key_ready drops the next cycle.
  - EMIT: beat 0 is registered and visible with rk_valid=1 exactly one cycle after the key handshake.
- Shift schedule s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt: CD_i = rotl(CD_{i-1}, s_i) on C and D independently; K_i = PC-2(CD_i).
- Decrypt: CD_16 = CD_0, so K16 = PC-2(CD_0); CD_{i-1} = rotr(CD_i, s_i); K_{i-1} = PC-2(CD_{i-1}).
- Each beat combinationally chains KEYS_PER_CYCLE rotate stages from the CD register. The register advances by the whole chain only on a beat handshake.
- Output stability: while rk_valid && !rk_ready, rk_data, rk_index and rk_last hold constant.
- Beat count is 16/KEYS_PER_CYCLE.
  - rk_index advances by +KEYS_PER_CYCLE for encrypt, starting at 0.
  - For decrypt it starts at 15 and decrements by KEYS_PER_CYCLE; it names the first key of the beat.
- rk_last=1 only on the final beat. On that beat's handshake: rk_valid <= 0, rk_last <= 0, return to IDLE, key_ready=1 the following cycle. Keys are therefore spaced by at least 16/KEYS_PER_CYCLE+1 cycles.
- key_valid during EMIT is ignored; the key is not captured.
- decrypt and key_in are sampled only at the accept handshake; later changes have no effect.
- rst_n asserted mid-stream aborts immediately. No further beats; the next key after release starts from beat 0.
- After 16 rounds the total rotation is 28, so CD returns to PC-1(key). The implementation discards CD at IDLE regardless.

Optional Feature:
- Macro DES_KEY_PARITY_CHK_EN.
- Defined: adds output parity_err (1 bit, reset 0). At accept, each key byte key_in[8b+7:8b] must have odd parity.
  - On any failure: no round keys are emitted, parity_err pulses high for exactly one cycle (the cycle after accept), and the block returns to IDLE.
  - key_ready is 1 again on the cycle after the pulse.
- Not defined: no parity_err port; parity bits are ignored and every key is scheduled.

Test Plan:
- KEYS_PER_CYCLE=1, decrypt=0, key_in = bit-reverse(0x133457799BBCDFF1), rk_ready=1 -> 16 beats on consecutive cycles; beat0 rk_data=0x1B02EFFC7072, rk_index=0; beat1=0x79AED9DBC9E5; beat15=0xCB3D8B0E17F5 with rk_last=1, rk_index=15.
- Same key, decrypt=1 -> beat0=0xCB3D8B0E17F5, rk_index=15; beat15=0x1B02EFFC7072, rk_index=0, rk_last=1.
- KEYS_PER_CYCLE=4, same key, encrypt -> 4 beats; beat0 rk_data[191:144]=0x1B02EFFC7072, rk_data[143:96]=0x79AED9DBC9E5, rk_index 0,4,8,12.
- Backpressure: rk_ready toggled 0/1 every cycle, plus key_valid pulsed during EMIT with a different key -> outputs held while stalled; the same 16 keys are produced; the second key is not captured; key_ready=0 until the cycle after the last handshake.
- rst_n low after beat 5 of a key, then a new key 0x0101010101010101 (parity-valid) -> rk_valid=0 within the reset; the new stream starts with rk_index=0.
- DES_KEY_PARITY_CHK_EN defined, key 0x0001010101010101 -> parity_err=1 for one cycle, no rk_valid, key_ready=1 on the next cycle.
